// File: rtl/seq_det_param_if.sv
// Bundle of the serial/config/result signals for seq_det_param.
// match_cnt exists only when SEQ_DET_MATCH_CNT_EN is defined.
interface seq_det_param_if #(
    parameter int PAT_N = 4,
    parameter int CNT_W = 8
);
    logic             din;
    logic             din_vld;
    logic             cfg_load;
    logic [PAT_N-1:0] cfg_pattern;
    logic             cfg_overlap;
    logic             dout;
`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] match_cnt;
`endif

    modport master (
`ifdef SEQ_DET_MATCH_CNT_EN
        input  match_cnt,
`endif
        output din, din_vld, cfg_load, cfg_pattern, cfg_overlap,
        input  dout
    );

    modport slave (
`ifdef SEQ_DET_MATCH_CNT_EN
        output match_cnt,
`endif
        input  din, din_vld, cfg_load, cfg_pattern, cfg_overlap,
        output dout
    );

    // Reject widths the detector cannot be built with.
    generate
        if (PAT_N < 2 || PAT_N > 16 || CNT_W < 1) begin : g_bad_param
            $error("seq_det_param_if: illegal PAT_N or CNT_W");
        end
    endgenerate
endinterface

// File: rtl/seq_det_param.sv
// Runtime-programmable PAT_N-bit serial sequence detector with optional
// overlapping detection and a registered one-cycle match pulse.
// Optional feature macro: SEQ_DET_MATCH_CNT_EN adds a saturating match counter.
// The detector keeps the last PAT_N-1 accepted bits plus a fill count instead
// of a per-prefix FSM; the port behaviour is identical to that FSM.
module seq_det_param #(
    parameter int               PAT_N       = 4,
    parameter logic [PAT_N-1:0] PAT_DEFAULT = 4'b1001,
    parameter int               CNT_W       = 8
) (
    input  logic           clk,
    input  logic           rst,
    seq_det_param_if.slave bus
);
    // fill only has to reach PAT_N-1, so clog2(PAT_N) bits suffice.
    localparam int                FILL_W   = $clog2(PAT_N);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_N - 1);

    logic [PAT_N-2:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PAT_N-1:0]  pat_q, pat_d;
    logic              ovl_q, ovl_d;
    logic              dout_q, dout_d;
    logic [PAT_N-1:0]  window;
    logic              match;

    generate
        if (PAT_N < 2 || PAT_N > 16 || CNT_W < 1) begin : g_bad_param
            $error("seq_det_param: illegal PAT_N or CNT_W");
        end
    endgenerate

    // Next-state for history, fill level, configuration and match pulse.
    always_comb begin
        window = {hist_q, bus.din};
        match  = bus.din_vld && !bus.cfg_load && (fill_q == FILL_MAX) && (window == pat_q);
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        ovl_d  = ovl_q;
        dout_d = 1'b0;
        if (bus.cfg_load) begin
            pat_d  = bus.cfg_pattern;
            ovl_d  = bus.cfg_overlap;
            hist_d = '0;
            fill_d = '0;
        end else if (bus.din_vld) begin
            // Slicing the window also covers PAT_N=2, where hist is one bit.
            hist_d = window[PAT_N-2:0];
            dout_d = match;
            if (match) begin
                fill_d = ovl_q ? FILL_MAX : '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    // State registers, cleared immediately by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= PAT_DEFAULT;
            ovl_q  <= 1'b0;
            dout_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            ovl_q  <= ovl_d;
            dout_q <= dout_d;
        end
    end

    assign bus.dout = dout_q;

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

    // Saturating count of matches; reloaded to zero with each new pattern.
    always_comb begin
        match_cnt_d = match_cnt_q;
        if (bus.cfg_load) begin
            match_cnt_d = '0;
        end else if (match && (match_cnt_q != {CNT_W{1'b1}})) begin
            match_cnt_d = match_cnt_q + 1'b1;
        end
    end

    // Counter register, updated on the same edge that raises dout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_cnt_q <= '0;
        end else begin
            match_cnt_q <= match_cnt_d;
        end
    end

    assign bus.match_cnt = match_cnt_q;
`endif
endmodule

// File: tb/tb_seq_det_param.sv
// Bench for seq_det_param: PAT_N=4, CNT_W=2. Counter checks are active when
// SEQ_DET_MATCH_CNT_EN is defined.
module tb_seq_det_param;
    localparam int PAT_N = 4;
    localparam int CNT_W = 2;

    typedef struct packed {
        logic             load;
        logic [PAT_N-1:0] pat;
        logic             ovl;
        logic             vld;
        logic             din;
        logic             exp_dout;
        logic [CNT_W-1:0] exp_cnt;
    } vec_t;

    typedef struct packed {
        logic             dout;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    exp_t sb[$];

    seq_det_param_if #(.PAT_N(PAT_N), .CNT_W(CNT_W)) bus ();

    seq_det_param #(.PAT_N(PAT_N), .PAT_DEFAULT(4'b1001), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t ld(input logic [PAT_N-1:0] p, input logic o, input logic d);
        return '{load: 1'b1, pat: p, ovl: o, vld: 1'b1, din: d, exp_dout: 1'b0, exp_cnt: '0};
    endfunction

    function automatic vec_t bit_v(input logic d, input logic e, input logic [CNT_W-1:0] c);
        return '{load: 1'b0, pat: '0, ovl: 1'b0, vld: 1'b1, din: d, exp_dout: e, exp_cnt: c};
    endfunction

    // Idle cycle: din held at 1 so a detector ignoring din_vld would be caught.
    function automatic vec_t gap_v(input logic [CNT_W-1:0] c);
        return '{load: 1'b0, pat: '0, ovl: 1'b0, vld: 1'b0, din: 1'b1, exp_dout: 1'b0, exp_cnt: c};
    endfunction

    task automatic check_now(input string tag, input logic e_dout, input logic [CNT_W-1:0] e_cnt);
        checks++;
        if (bus.dout !== e_dout) begin
            errors++;
            $display("FAIL %s dout: got %b want %b", tag, bus.dout, e_dout);
        end
`ifdef SEQ_DET_MATCH_CNT_EN
        checks++;
        if (bus.match_cnt !== e_cnt) begin
            errors++;
            $display("FAIL %s match_cnt: got %0d want %0d", tag, bus.match_cnt, e_cnt);
        end
`else
        if (e_cnt === 'x) $display("note: unknown expected count in %s", tag);
`endif
    endtask

    // Drive one cycle, queue its expectation, compare just after the edge.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        bus.cfg_load    = v.load;
        bus.cfg_pattern = v.pat;
        bus.cfg_overlap = v.ovl;
        bus.din_vld     = v.vld;
        bus.din         = v.din;
        sb.push_back('{dout: v.exp_dout, cnt: v.exp_cnt});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard: got empty queue want one entry", tag);
        end else begin
            e = sb.pop_front();
            check_now(tag, e.dout, e.cnt);
        end
        @(negedge clk);
    endtask

    initial begin
        rst             = 1'b1;
        bus.din         = 1'b0;
        bus.din_vld     = 1'b0;
        bus.cfg_load    = 1'b0;
        bus.cfg_pattern = '0;
        bus.cfg_overlap = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_now("reset", 1'b0, 2'd0);
        @(negedge clk);
        rst = 1'b0;

        // Non-overlap 1001: one pulse after bit 4, none after bit 7.
        vecs.push_back(ld(4'b1001, 1'b0, 1'b1));
        vecs.push_back(bit_v(1, 0, 0)); vecs.push_back(bit_v(0, 0, 0));
        vecs.push_back(bit_v(0, 0, 0)); vecs.push_back(bit_v(1, 1, 1));
        vecs.push_back(bit_v(0, 0, 1)); vecs.push_back(bit_v(0, 0, 1));
        vecs.push_back(bit_v(1, 0, 1)); vecs.push_back(gap_v(1));
        // Overlap 1001: pulses after bits 4 and 7.
        vecs.push_back(ld(4'b1001, 1'b1, 1'b0));
        vecs.push_back(bit_v(1, 0, 0)); vecs.push_back(bit_v(0, 0, 0));
        vecs.push_back(bit_v(0, 0, 0)); vecs.push_back(bit_v(1, 1, 1));
        vecs.push_back(bit_v(0, 0, 1)); vecs.push_back(bit_v(0, 0, 1));
        vecs.push_back(bit_v(1, 1, 2)); vecs.push_back(gap_v(2));
        // Valid gaps of three cycles between bits.
        vecs.push_back(ld(4'b1001, 1'b0, 1'b0));
        vecs.push_back(bit_v(1, 0, 0));
        for (int g = 0; g < 3; g++) vecs.push_back(gap_v(0));
        vecs.push_back(bit_v(0, 0, 0));
        for (int g = 0; g < 3; g++) vecs.push_back(gap_v(0));
        vecs.push_back(bit_v(0, 0, 0));
        for (int g = 0; g < 3; g++) vecs.push_back(gap_v(0));
        vecs.push_back(bit_v(1, 1, 1)); vecs.push_back(gap_v(1));
        // Reprogram mid-stream to 0110.
        vecs.push_back(ld(4'b1001, 1'b0, 1'b0));
        vecs.push_back(bit_v(1, 0, 0)); vecs.push_back(bit_v(0, 0, 0));
        vecs.push_back(bit_v(0, 0, 0));
        vecs.push_back(ld(4'b0110, 1'b0, 1'b1));
        vecs.push_back(bit_v(1, 0, 0)); vecs.push_back(bit_v(0, 0, 0));
        vecs.push_back(bit_v(1, 0, 0)); vecs.push_back(bit_v(1, 0, 0));
        vecs.push_back(bit_v(0, 1, 1));
        // Self-overlapping 1111, eight ones: five pulses, count saturates at 3.
        vecs.push_back(ld(4'b1111, 1'b1, 1'b0));
        vecs.push_back(bit_v(1, 0, 0)); vecs.push_back(bit_v(1, 0, 0));
        vecs.push_back(bit_v(1, 0, 0)); vecs.push_back(bit_v(1, 1, 1));
        vecs.push_back(bit_v(1, 1, 2)); vecs.push_back(bit_v(1, 1, 3));
        vecs.push_back(bit_v(1, 1, 3)); vecs.push_back(bit_v(1, 1, 3));

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Reset between edges while dout is high and the count is 3.
        rst = 1'b1;
        #1;
        check_now("async_rst_pulse", 1'b0, 2'd0);
        @(negedge clk);
        rst = 1'b0;

        // Partial 1,0,0 under default pattern, then reset mid-cycle.
        apply(bit_v(1, 0, 0), "pre_rst_b1");
        apply(bit_v(0, 0, 0), "pre_rst_b2");
        apply(bit_v(0, 0, 0), "pre_rst_b3");
        #3;
        rst = 1'b1;
        #1;
        check_now("async_rst_mid", 1'b0, 2'd0);
        @(negedge clk);
        rst = 1'b0;

        // Old partial discarded; default pattern and non-overlap restored.
        apply(bit_v(1, 0, 0), "post_rst_b1");
        apply(bit_v(0, 0, 0), "post_rst_b2");
        apply(bit_v(0, 0, 0), "post_rst_b3");
        apply(bit_v(1, 1, 1), "post_rst_b4");
        apply(bit_v(0, 0, 1), "post_rst_b5");
        apply(bit_v(0, 0, 1), "post_rst_b6");
        apply(bit_v(1, 0, 1), "post_rst_b7");
        apply(gap_v(1), "post_rst_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_det_param.md
Name: seq_det_param

Overview:
- Parametrised serial sequence detector; the next generation of the fixed 4-bit FSM detector.
- Detects a runtime-programmable PAT_N-bit pattern on a 1-bit stream qualified by a valid strobe.
- Overlapping or non-overlapping detection is selected at runtime.
- Sits between a serial source and downstream control logic; emits a registered one-cycle match pulse and, optionally, a match count.

Parameters:
- PAT_N, 4, pattern length in bits; legal range 2..16.
- PAT_DEFAULT, 4'b1001 (PAT_N bits), pattern value loaded at reset.
- CNT_W, 8, width of the match counter.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  1  serial data bit.
- din_vld  in  1  din is sampled only on cycles where this is 1.
- cfg_load  in  1  one-cycle strobe that latches cfg_pattern and cfg_overlap and clears detection history.
- cfg_pattern  in  PAT_N  new pattern; bit PAT_N-1 is the first bit received.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- dout  out  1  registered match pulse.
- match_cnt  out  CNT_W  saturating match count (present only with MATCH_CNT_EN).

Behaviour:
- Reset (asynchronous, immediate on rst=1):
  - dout=0, hist=0, fill=0, pat_r=PAT_DEFAULT, ovl_r=0, match_cnt=0.
  - Reset mid-stream discards all partial matches.
- Internal state:
  - hist: PAT_N-1 bit shift register holding the previously accepted bits.
  - fill: count of accepted bits since the last clear, saturating at PAT_N-1.
- Priority per cycle, highest first: rst, then cfg_load, then din_vld.
- cfg_load=1:
  - pat_r<=cfg_pattern, ovl_r<=cfg_overlap, hist<=0, fill<=0, dout<=0.
  - Any din on the same cycle is discarded.
- din_vld=1 and cfg_load=0:
  - hist<={hist[PAT_N-3:0],din}.
  - match = (fill==PAT_N-1) && ({hist,din}==pat_r).
  - dout<=match. Latency is 1 cycle: dout is high in the cycle after the final pattern bit is sampled, for exactly one cycle.
  - On a match with ovl_r=0, fill<=0, so a new match needs PAT_N fresh bits.
  - On a match with ovl_r=1, fill stays at PAT_N-1, so suffix bits may start the next match.
  - With no match, fill<=min(fill+1, PAT_N-1).
- din_vld=0: hist and fill hold; dout<=0. Gaps never break a partial match.
- Pattern alignment: the oldest accepted bit compares against pat_r[PAT_N-1], and din against pat_r[0].
- Patterns with self-overlap (e.g. 1111, 1010) follow the same rules; no special cases.
- No FSM encoding is exposed. Equivalence with the classic state-per-prefix FSM is required at the ports.

Optional Feature:
- Macro: SEQ_DET_MATCH_CNT_EN.
- Defined:
  - match_cnt port exists.
  - Increments by 1 on each cycle where match is computed true, visible in the same cycle dout rises.
  - Saturates at all-ones with no wrap.
  - Cleared by rst and by cfg_load.
- Undefined: match_cnt port and its register are absent. All other behaviour is identical.

Test Plan:
- Non-overlap, PAT_N=4, pattern 1001: stream 1,0,0,1,0,0,1 with din_vld=1 every cycle -> dout pulses once, the cycle after bit 4; no pulse after bit 7.
- Overlap: cfg_load with 1001 and cfg_overlap=1, same stream -> dout pulses after bit 4 and after bit 7; match_cnt=2.
- Valid gaps: bits 1,0,0,1 with din_vld low for 3 cycles between each bit -> single dout pulse one cycle after the last valid bit; dout stays 0 during the gaps.
- Reprogram mid-stream: send 1,0,0, then cfg_load with 0110 -> history cleared. Then 1,0,1,1,0 -> exactly one pulse, after the final 0; no pulse from pre-load bits.
- Async reset: rst asserted between clock edges after 1,0,0 -> dout=0 and match_cnt=0 immediately. After release, 1 alone gives no pulse; 1,0,0,1 gives one pulse.
- Saturation and self-overlap: CNT_W=2, pattern 1111, overlap=1, eight consecutive 1s -> dout high on 5 cycles; match_cnt reads 3 and holds 3.
